// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: EX-stage control registers, RF read address steering, load-use stall.
// Optional ID_EX_PERF_CNT_EN adds saturating stall/bubble counters.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [4:0]        i_id_rs1,
  input  logic [4:0]        i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [4:0]        i_id_rd,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_mem_write,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic              i_flush,
  input  logic              i_hold,
  output logic [4:0]        o_rf_a1,
  output logic [4:0]        o_rf_a2,
  input  logic [XLEN-1:0]   i_rf_rd1,
  input  logic [XLEN-1:0]   i_rf_rd2,
  output logic              o_stall,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [4:0]        o_ex_rs1,
  output logic [4:0]        o_ex_rs2,
  output logic [4:0]        o_ex_rd,
  output logic              o_ex_reg_write,
  output logic              o_ex_mem_read,
  output logic              o_ex_mem_write,
  output logic [CTRL_W-1:0] o_ex_ctrl,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt,
`endif
  output logic [XLEN-1:0]   o_ex_rd1,
  output logic [XLEN-1:0]   o_ex_rd2
);

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_imm;
  logic [4:0]        r_ex_rs1;
  logic [4:0]        r_ex_rs2;
  logic [4:0]        r_ex_rd;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic              r_ex_mem_write;
  logic [CTRL_W-1:0] r_ex_ctrl;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hazard;
  logic w_bubble;
  logic w_hold_eff;

  // x0 never matches because an EX rd of 0 is excluded outright.
  assign w_rs1_hit  = i_id_use_rs1 & (i_id_rs1 == r_ex_rd);
  assign w_rs2_hit  = i_id_use_rs2 & (i_id_rs2 == r_ex_rd);
  assign w_hazard   = i_id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);
  assign w_hold_eff = i_hold & ~i_flush;
  assign w_bubble   = i_flush | (~i_hold & w_hazard);

  assign o_stall = i_rst_n & ~i_flush & (i_hold | w_hazard);

  // During a hold the file re-reads the held instruction's sources so data tracks control.
  assign o_rf_a1 = w_hold_eff ? r_ex_rs1 : i_id_rs1;
  assign o_rf_a2 = w_hold_eff ? r_ex_rs2 : i_id_rs2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || w_bubble) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_imm       <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_ctrl      <= '0;
    end else if (!i_hold) begin
      r_ex_valid     <= i_id_valid;
      r_ex_pc        <= i_id_pc;
      r_ex_imm       <= i_id_imm;
      r_ex_rs1       <= i_id_rs1;
      r_ex_rs2       <= i_id_rs2;
      r_ex_rd        <= i_id_rd;
      r_ex_reg_write <= i_id_valid & i_id_reg_write;
      r_ex_mem_read  <= i_id_valid & i_id_mem_read;
      r_ex_mem_write <= i_id_valid & i_id_mem_write;
      r_ex_ctrl      <= i_id_ctrl;
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_pc        = r_ex_pc;
  assign o_ex_imm       = r_ex_imm;
  assign o_ex_rs1       = r_ex_rs1;
  assign o_ex_rs2       = r_ex_rs2;
  assign o_ex_rd        = r_ex_rd;
  assign o_ex_reg_write = r_ex_reg_write;
  assign o_ex_mem_read  = r_ex_mem_read;
  assign o_ex_mem_write = r_ex_mem_write;
  assign o_ex_ctrl      = r_ex_ctrl;
  assign o_ex_rd1       = i_rf_rd1;
  assign o_ex_rd2       = i_rf_rd2;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_hazard && !i_flush && !i_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a small registered-read register file model.
module tb_id_ex_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 8;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_id_valid, i_id_use_rs1, i_id_use_rs2;
  logic [XLEN-1:0]   i_id_pc, i_id_imm;
  logic [4:0]        i_id_rs1, i_id_rs2, i_id_rd;
  logic              i_id_reg_write, i_id_mem_read, i_id_mem_write;
  logic [CTRL_W-1:0] i_id_ctrl;
  logic              i_flush, i_hold;
  logic [4:0]        o_rf_a1, o_rf_a2;
  logic [XLEN-1:0]   i_rf_rd1, i_rf_rd2;
  logic              o_stall, o_ex_valid;
  logic [XLEN-1:0]   o_ex_pc, o_ex_imm, o_ex_rd1, o_ex_rd2;
  logic [4:0]        o_ex_rs1, o_ex_rs2, o_ex_rd;
  logic              o_ex_reg_write, o_ex_mem_read, o_ex_mem_write;
  logic [CTRL_W-1:0] o_ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       o_stall_cnt, o_bubble_cnt;
`endif

  logic [XLEN-1:0] rf [32];
  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  // Register file model: read data registered on the same posedge as the stage.
  always @(posedge i_clk) begin
    i_rf_rd1 <= rf[o_rf_a1];
    i_rf_rd2 <= rf[o_rf_a2];
  end

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_valid(i_id_valid), .i_id_pc(i_id_pc), .i_id_imm(i_id_imm),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_id_rd(i_id_rd), .i_id_reg_write(i_id_reg_write),
    .i_id_mem_read(i_id_mem_read), .i_id_mem_write(i_id_mem_write),
    .i_id_ctrl(i_id_ctrl), .i_flush(i_flush), .i_hold(i_hold),
    .o_rf_a1(o_rf_a1), .o_rf_a2(o_rf_a2), .i_rf_rd1(i_rf_rd1), .i_rf_rd2(i_rf_rd2),
    .o_stall(o_stall), .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_imm(o_ex_imm),
    .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
    .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
    .o_ex_mem_write(o_ex_mem_write), .o_ex_ctrl(o_ex_ctrl),
`ifdef ID_EX_PERF_CNT_EN
    .o_stall_cnt(o_stall_cnt), .o_bubble_cnt(o_bubble_cnt),
`endif
    .o_ex_rd1(o_ex_rd1), .o_ex_rd2(o_ex_rd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic mr);
    i_id_valid = v; i_id_pc = pc; i_id_imm = pc + 32'h4;
    i_id_rs1 = rs1; i_id_use_rs1 = u1; i_id_rs2 = rs2; i_id_use_rs2 = u2;
    i_id_rd = rd; i_id_reg_write = rw; i_id_mem_read = mr; i_id_mem_write = 1'b0;
    i_id_ctrl = 8'h5A;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    i_rst_n = 1'b0; i_flush = 1'b0; i_hold = 1'b1;
    id_set(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_hold = 1'b0;

    // Straight flow
    rf[3] = 32'd7; rf[4] = 32'd9;
    id_set(1'b1, 32'h100, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    chk("flow_stall0", {31'd0, o_stall}, 32'd0);
    chk("flow_a1", {27'd0, o_rf_a1}, 32'd3);
    step();
    chk("flow_valid", {31'd0, o_ex_valid}, 32'd1);
    chk("flow_pc", o_ex_pc, 32'h100);
    chk("flow_rd", {27'd0, o_ex_rd}, 32'd5);
    chk("flow_rd1", o_ex_rd1, 32'd7);
    chk("flow_rd2", o_ex_rd2, 32'd9);
    chk("flow_ctrl", {24'd0, o_ex_ctrl}, 32'h5A);

    // Load-use: lw x6 then add using x6
    id_set(1'b1, 32'h104, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    #1;
    chk("lw_stall0", {31'd0, o_stall}, 32'd0);
    step();
    chk("lw_mr", {31'd0, o_ex_mem_read}, 32'd1);
    id_set(1'b1, 32'h108, 5'd6, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    chk("lu_stall1", {31'd0, o_stall}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, o_ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, o_ex_reg_write}, 32'd0);
    chk("lu_stall_drop", {31'd0, o_stall}, 32'd0);
    step();
    chk("lu_enter_valid", {31'd0, o_ex_valid}, 32'd1);
    chk("lu_enter_pc", o_ex_pc, 32'h108);

    // x0 destination never hazards
    id_set(1'b1, 32'h10C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    id_set(1'b1, 32'h110, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    #1;
    chk("x0_nostall", {31'd0, o_stall}, 32'd0);
    // lw x6, then ID reads x6 only via an unused rs2
    id_set(1'b1, 32'h114, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    id_set(1'b1, 32'h118, 5'd2, 1'b1, 5'd6, 1'b0, 5'd1, 1'b1, 1'b0);
    #1;
    chk("unused_rs2", {31'd0, o_stall}, 32'd0);
    i_id_use_rs2 = 1'b1;
    #1;
    chk("used_rs2", {31'd0, o_stall}, 32'd1);
    // Flush wins over the hazard
    i_flush = 1'b1;
    #1;
    chk("flush_haz_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("flush_haz_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("flush_haz_mr", {31'd0, o_ex_mem_read}, 32'd0);

    // Flush wins over hold
    i_flush = 1'b0;
    id_set(1'b1, 32'h11C, 5'd3, 1'b1, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0);
    step();
    chk("pre_fh_valid", {31'd0, o_ex_valid}, 32'd1);
    i_flush = 1'b1; i_hold = 1'b1;
    #1;
    chk("flush_hold_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("flush_hold_valid", {31'd0, o_ex_valid}, 32'd0);

    // Hold for 3 cycles with writeback to x3 mid-hold
    i_flush = 1'b0; i_hold = 1'b0;
    id_set(1'b1, 32'h200, 5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    chk("hold_pre_rd1", o_ex_rd1, 32'd7);
    i_hold = 1'b1;
    id_set(1'b1, 32'h300, 5'd10, 1'b1, 5'd11, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    chk("hold_a1", {27'd0, o_rf_a1}, 32'd3);
    chk("hold_stall_c1", {31'd0, o_stall}, 32'd1);
    step();
    chk("hold_pc_c1", o_ex_pc, 32'h200);
    rf[3] = 32'h55;
    chk("hold_stall_c2", {31'd0, o_stall}, 32'd1);
    step();
    chk("hold_rd1_fresh", o_ex_rd1, 32'h55);
    chk("hold_pc_c2", o_ex_pc, 32'h200);
    chk("hold_rs1", {27'd0, o_ex_rs1}, 32'd3);
    chk("hold_stall_c3", {31'd0, o_stall}, 32'd1);
    step();
    chk("hold_rd_c3", {27'd0, o_ex_rd}, 32'd8);
    i_hold = 1'b0;
    #1;
    chk("hold_a1_rel", {27'd0, o_rf_a1}, 32'd10);
    step();
    chk("hold_rel_pc", o_ex_pc, 32'h300);

    // Async reset mid-run with a valid EX instruction and a hold pending
    i_hold = 1'b1;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_ex_valid}, 32'd0);
    chk("arst_rw", {31'd0, o_ex_reg_write}, 32'd0);
    chk("arst_stall", {31'd0, o_stall}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1; i_hold = 1'b0;
    id_set(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    chk("post_rst_valid", {31'd0, o_ex_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX boundary of the pipelined core. It captures decoded instruction fields into EX-stage registers and drives the register-file read addresses.
- The register file returns read data registered on the same posedge. This block therefore forwards that data to EX unregistered, aligned with its own registered control.
- It detects load-use hazards, inserts bubbles, honours branch flush and downstream hold.

Parameters:
XLEN, 32, datapath width (pc, imm, register data)
CTRL_W, 8, width of opaque ALU/branch control bundle carried to EX

Ports:
i_clk  in  1  core clock, all state updates on posedge
i_rst_n  in  1  asynchronous active-low reset
i_id_valid  in  1  ID holds a real instruction
i_id_pc  in  XLEN  instruction PC
i_id_imm  in  XLEN  decoded immediate
i_id_rs1  in  5  source register 1
i_id_rs2  in  5  source register 2
i_id_use_rs1  in  1  instruction reads rs1
i_id_use_rs2  in  1  instruction reads rs2
i_id_rd  in  5  destination register
i_id_reg_write  in  1  writes rd
i_id_mem_read  in  1  is a load
i_id_mem_write  in  1  is a store
i_id_ctrl  in  CTRL_W  opaque control bundle
i_flush  in  1  branch/jump taken in EX; kill ID instruction
i_hold  in  1  downstream stall (e.g. memory wait)
o_rf_a1  out  5  register-file read address 1
o_rf_a2  out  5  register-file read address 2
i_rf_rd1  in  XLEN  register-file read data 1 (registered by the file)
i_rf_rd2  in  XLEN  register-file read data 2
o_stall  out  1  freeze PC and IF/ID this cycle
o_ex_valid, o_ex_pc, o_ex_imm, o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_ctrl  out  (widths as inputs)  EX-stage registered copies
o_ex_rd1, o_ex_rd2  out  XLEN  operand data = i_rf_rd1/i_rf_rd2 passthrough

Behaviour:
- Reset (async, i_rst_n=0): all o_ex_* registers cleared to 0 (o_ex_valid=0, so the EX slot is a bubble). o_stall=0 while in reset.
- hazard (combinational) = i_id_valid & o_ex_valid & o_ex_mem_read & (o_ex_rd!=0) & ((i_id_use_rs1 & i_id_rs1==o_ex_rd) | (i_id_use_rs2 & i_id_rs2==o_ex_rd)).
- Registers never match x0; rs fields of 0 never cause a hazard.
- o_stall = ~i_flush & (i_hold | hazard).
- Posedge update priority:
  - i_flush: EX loads a bubble (valid, reg_write, mem_read, mem_write cleared; other fields don't-care, implement as 0).
  - else i_hold: all EX registers keep their values.
  - else hazard: EX loads a bubble; ID is frozen by o_stall, so the instruction is re-presented next cycle.
  - else: EX loads the ID fields. valid/reg_write/mem_read/mem_write are gated with i_id_valid.
- Read addresses: o_rf_a1/o_rf_a2 = i_id_rs1/i_id_rs2, except under (i_hold & ~i_flush), where they are o_ex_rs1/o_ex_rs2. This makes the file re-read the held instruction's sources and keeps o_ex_rd1/rd2 consistent with held control.
- Re-reads during hold observe any writeback completed meanwhile (fresher value, intended).
- Latency: one cycle from ID to EX for control; data aligned by the file's posedge read.
- A load-use stall costs exactly one bubble. After the bubble, o_ex_mem_read=0 in EX, so hazard drops.
- i_flush with hazard in the same cycle: flush wins, no stall, bubble inserted.
- i_flush with i_hold in the same cycle: flush wins.
- Reset mid-stall: state is cleared immediately; no pending bubble survives.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds outputs o_stall_cnt and o_bubble_cnt (32 bits each), reset to 0.
  - o_stall_cnt: +1 per cycle with hazard & ~i_flush & ~i_hold.
  - o_bubble_cnt: +1 per cycle a bubble is loaded (flush or hazard).
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset: drive i_rst_n=0 mid-run with o_ex_valid=1 -> o_ex_valid=0 and o_ex_reg_write=0 immediately (async), o_stall=0.
- Straight flow: ID add rs1=3 rs2=4 rd=5 pc=0x100, register file holding x3=7 and x4=9 -> next cycle o_ex_pc=0x100, o_ex_rd=5, o_ex_rd1=7, o_ex_rd2=9, o_stall=0 throughout.
- Load-use: EX holds lw rd=6, ID add rs1=6 -> o_stall=1 for one cycle, then o_ex_valid=0 (bubble); following cycle add enters EX, o_stall=0.
- x0 / unused source: EX lw rd=0 with ID rs1=0 -> no stall. EX lw rd=6 with ID rs2=6, use_rs2=0 -> no stall.
- Flush priority: flush asserted together with a load-use hazard -> o_stall=0 and EX receives a bubble. Flush together with i_hold -> bubble, no hold.
- Hold: i_hold=1 for 3 cycles with EX rs1=3, and a writeback to x3=0x55 during the hold -> EX fields unchanged, o_rf_a1=3, o_ex_rd1=0x55 after the write, o_stall=1 for all 3 cycles.
